// File: rtl/uart_pkg.sv
// Shared definitions for the uart_trx transceiver: parity codes, FSM states,
// and the frame length rule.
package uart_pkg;

    localparam int PAR_NONE = 0;
    localparam int PAR_ODD  = 1;
    localparam int PAR_EVEN = 2;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_START,
        ST_DATA,
        ST_PARITY,
        ST_STOP
    } uart_state_e;

    function automatic int frame_bits(input int data_bits, input int parity, input int stop_bits);
        return 1 + data_bits + ((parity != PAR_NONE) ? 1 : 0) + stop_bits;
    endfunction

endpackage

// File: rtl/uart_bit_timer.sv
// Free-running bit timer: counts 0..BAUD-1 and wraps. It is held at zero
// while clear is high, so the first count after release is a full bit.
module uart_bit_timer #(
    parameter int BAUD = 5207
) (
    input  logic clk,
    input  logic rst,
    input  logic clear,
    output logic tick,
    output logic half
);

    localparam int CW = (BAUD > 1) ? $clog2(BAUD) : 1;
    localparam logic [CW-1:0] LAST = CW'(BAUD - 1);
    localparam logic [CW-1:0] MID  = CW'(BAUD / 2);

    logic [CW-1:0] cnt_q, cnt_d;

    always_comb begin
        cnt_d = cnt_q + CW'(1);
        if (clear || (cnt_q == LAST)) begin
            cnt_d = '0;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    assign tick = !clear && (cnt_q == LAST);
    assign half = !clear && (cnt_q == MID);

endmodule

// File: rtl/uart_trx.sv
// Full-duplex UART with configurable data bits, parity and stop bits.
// TX and RX are independent FSMs sharing only the clock and reset.
//
// state     | meaning
// ST_IDLE   | line idle; TX waits for send_start, RX waits for a falling edge
// ST_START  | TX drives the start bit; RX waits for the mid-bit start check
// ST_DATA   | data bits, LSB first; bit count in *_cnt_q
// ST_PARITY | optional parity bit
// ST_STOP   | stop bit(s); RX leaves at the last stop sample point
module uart_trx
    import uart_pkg::*;
#(
    parameter int BAUD      = 5207,
    parameter int DATA_BITS = 8,
    parameter int PARITY    = 0,
    parameter int STOP_BITS = 1
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 send_start,
    input  logic [DATA_BITS-1:0] send_data,
    output logic                 send_busy,
    output logic                 send_finish,
    output logic                 uart_dout,
    input  logic                 uart_din,
    output logic                 receive_start,
    output logic                 receive_busy,
    output logic                 receive_finish,
    output logic [DATA_BITS-1:0] receive_data,
    output logic                 receive_parity_err,
    output logic                 receive_frame_err
);

    localparam logic [3:0] LAST_DATA = 4'(DATA_BITS - 1);
    localparam logic [3:0] LAST_STOP = 4'(STOP_BITS - 1);
    localparam logic       HAS_PAR   = (PARITY != PAR_NONE);
    localparam logic       ODD       = (PARITY == PAR_ODD);

    // ---------------------------------------------------------------- TX
    uart_state_e          tx_state_q, tx_state_d;
    logic [DATA_BITS-1:0] tx_shift_q, tx_shift_d;
    logic                 tx_par_q, tx_par_d;
    logic [3:0]           tx_cnt_q, tx_cnt_d;
    logic                 tx_dout_q, tx_dout_d;
    logic                 tx_tick, tx_half_unused;

    uart_bit_timer #(.BAUD(BAUD)) u_tx_timer (
        .clk   (clk),
        .rst   (rst),
        .clear (tx_state_q == ST_IDLE),
        .tick  (tx_tick),
        .half  (tx_half_unused)
    );

    always_comb begin
        tx_state_d  = tx_state_q;
        tx_shift_d  = tx_shift_q;
        tx_par_d    = tx_par_q;
        tx_cnt_d    = tx_cnt_q;
        send_finish = 1'b0;
        case (tx_state_q)
            ST_IDLE: begin
                if (send_start) begin
                    tx_shift_d = send_data;
                    tx_par_d   = ^send_data ^ ODD;
                    tx_cnt_d   = '0;
                    tx_state_d = ST_START;
                end
            end
            ST_START: begin
                if (tx_tick) tx_state_d = ST_DATA;
            end
            ST_DATA: begin
                if (tx_tick) begin
                    tx_shift_d = tx_shift_q >> 1;
                    if (tx_cnt_q == LAST_DATA) begin
                        tx_cnt_d   = '0;
                        tx_state_d = HAS_PAR ? ST_PARITY : ST_STOP;
                    end else begin
                        tx_cnt_d = tx_cnt_q + 4'd1;
                    end
                end
            end
            ST_PARITY: begin
                if (tx_tick) tx_state_d = ST_STOP;
            end
            ST_STOP: begin
                if (tx_tick) begin
                    if (tx_cnt_q == LAST_STOP) begin
                        send_finish = 1'b1;
                        tx_state_d  = ST_IDLE;
                    end else begin
                        tx_cnt_d = tx_cnt_q + 4'd1;
                    end
                end
            end
            default: tx_state_d = ST_IDLE;
        endcase

        // Output register is fed from next-state values so the pin is glitch-free.
        case (tx_state_d)
            ST_START:  tx_dout_d = 1'b0;
            ST_DATA:   tx_dout_d = tx_shift_d[0];
            ST_PARITY: tx_dout_d = tx_par_d;
            default:   tx_dout_d = 1'b1;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            tx_state_q <= ST_IDLE;
            tx_shift_q <= '0;
            tx_par_q   <= 1'b0;
            tx_cnt_q   <= '0;
            tx_dout_q  <= 1'b1;
        end else begin
            tx_state_q <= tx_state_d;
            tx_shift_q <= tx_shift_d;
            tx_par_q   <= tx_par_d;
            tx_cnt_q   <= tx_cnt_d;
            tx_dout_q  <= tx_dout_d;
        end
    end

    assign send_busy = (tx_state_q != ST_IDLE);
    assign uart_dout = tx_dout_q;

    // ---------------------------------------------------------------- RX
    logic                 rx_s1_q, rx_s2_q, rx_s3_q;
    uart_state_e          rx_state_q, rx_state_d;
    logic [DATA_BITS-1:0] rx_shift_q, rx_shift_d;
    logic [3:0]           rx_cnt_q, rx_cnt_d;
    logic                 rx_par_q, rx_par_d;
    logic                 rx_ferr_q, rx_ferr_d;
    logic [DATA_BITS-1:0] rx_data_q, rx_data_d;
    logic                 rx_perr_q, rx_perr_d;
    logic                 rx_fe_q, rx_fe_d;
    logic                 rx_half, rx_tick_unused;
    logic                 rx_bit, rx_fall;

    assign rx_bit  = rx_s2_q;
    assign rx_fall = rx_s3_q & ~rx_s2_q;

    uart_bit_timer #(.BAUD(BAUD)) u_rx_timer (
        .clk   (clk),
        .rst   (rst),
        .clear (rx_state_q == ST_IDLE),
        .tick  (rx_tick_unused),
        .half  (rx_half)
    );

    always_comb begin
        rx_state_d     = rx_state_q;
        rx_shift_d     = rx_shift_q;
        rx_cnt_d       = rx_cnt_q;
        rx_par_d       = rx_par_q;
        rx_ferr_d      = rx_ferr_q;
        rx_data_d      = rx_data_q;
        rx_perr_d      = rx_perr_q;
        rx_fe_d        = rx_fe_q;
        receive_start  = 1'b0;
        receive_finish = 1'b0;
        case (rx_state_q)
            ST_IDLE: begin
                if (rx_fall) rx_state_d = ST_START;
            end
            ST_START: begin
                if (rx_half) begin
                    if (rx_bit) begin
                        rx_state_d = ST_IDLE;
                    end else begin
                        receive_start = 1'b1;
                        rx_cnt_d      = '0;
                        rx_ferr_d     = 1'b0;
                        rx_state_d    = ST_DATA;
                    end
                end
            end
            ST_DATA: begin
                if (rx_half) begin
                    rx_shift_d = {rx_bit, rx_shift_q[DATA_BITS-1:1]};
                    if (rx_cnt_q == LAST_DATA) begin
                        rx_cnt_d   = '0;
                        rx_state_d = HAS_PAR ? ST_PARITY : ST_STOP;
                    end else begin
                        rx_cnt_d = rx_cnt_q + 4'd1;
                    end
                end
            end
            ST_PARITY: begin
                if (rx_half) begin
                    rx_par_d   = rx_bit;
                    rx_state_d = ST_STOP;
                end
            end
            ST_STOP: begin
                if (rx_half) begin
                    rx_ferr_d = rx_ferr_q | ~rx_bit;
                    if (rx_cnt_q == LAST_STOP) begin
                        receive_finish = 1'b1;
                        rx_data_d      = rx_shift_q;
                        rx_perr_d      = HAS_PAR && (rx_par_q != (^rx_shift_q ^ ODD));
                        rx_fe_d        = rx_ferr_q | ~rx_bit;
                        rx_state_d     = ST_IDLE;
                    end else begin
                        rx_cnt_d = rx_cnt_q + 4'd1;
                    end
                end
            end
            default: rx_state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            rx_s1_q    <= 1'b1;
            rx_s2_q    <= 1'b1;
            rx_s3_q    <= 1'b1;
            rx_state_q <= ST_IDLE;
            rx_shift_q <= '0;
            rx_cnt_q   <= '0;
            rx_par_q   <= 1'b0;
            rx_ferr_q  <= 1'b0;
            rx_data_q  <= '0;
            rx_perr_q  <= 1'b0;
            rx_fe_q    <= 1'b0;
        end else begin
            rx_s1_q    <= uart_din;
            rx_s2_q    <= rx_s1_q;
            rx_s3_q    <= rx_s2_q;
            rx_state_q <= rx_state_d;
            rx_shift_q <= rx_shift_d;
            rx_cnt_q   <= rx_cnt_d;
            rx_par_q   <= rx_par_d;
            rx_ferr_q  <= rx_ferr_d;
            rx_data_q  <= rx_data_d;
            rx_perr_q  <= rx_perr_d;
            rx_fe_q    <= rx_fe_d;
        end
    end

    // Results are presented in the finish cycle itself, then held.
    assign receive_busy       = (rx_state_q != ST_IDLE);
    assign receive_data       = rx_data_d;
    assign receive_parity_err = rx_perr_d;
    assign receive_frame_err  = rx_fe_d;

endmodule

// File: tb/tb_uart_trx.sv
// Randomized self-checking bench for uart_trx: three instances (8N1, 7E2 in
// loopback, 8O1 driven directly) compared against a frame-level model.
module tb_uart_trx;

    localparam int B = 16;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic rst;
    int   tests  = 0;
    int   errors = 0;

    // 8N1 instance, line either driven by the bench or looped back
    logic       a_ss, a_busy, a_fin, a_dout, a_din, a_rs, a_rb, a_rf, a_pe, a_fe;
    logic [7:0] a_sd, a_rd;
    logic       a_loop, a_drv;
    assign a_din = a_loop ? a_dout : a_drv;

    // 7E2 instance, permanent loopback
    logic       b_ss, b_busy, b_fin, b_dout, b_din, b_rs, b_rb, b_rf, b_pe, b_fe;
    logic [6:0] b_sd, b_rd;
    assign b_din = b_dout;

    // 8O1 instance, receiver driven by the bench
    logic       c_ss, c_busy, c_fin, c_dout, c_din, c_rs, c_rb, c_rf, c_pe, c_fe;
    logic [7:0] c_sd, c_rd;

    uart_trx #(.BAUD(B), .DATA_BITS(8), .PARITY(0), .STOP_BITS(1)) dut_a (
        .clk(clk), .rst(rst), .send_start(a_ss), .send_data(a_sd), .send_busy(a_busy),
        .send_finish(a_fin), .uart_dout(a_dout), .uart_din(a_din), .receive_start(a_rs),
        .receive_busy(a_rb), .receive_finish(a_rf), .receive_data(a_rd),
        .receive_parity_err(a_pe), .receive_frame_err(a_fe));

    uart_trx #(.BAUD(B), .DATA_BITS(7), .PARITY(2), .STOP_BITS(2)) dut_b (
        .clk(clk), .rst(rst), .send_start(b_ss), .send_data(b_sd), .send_busy(b_busy),
        .send_finish(b_fin), .uart_dout(b_dout), .uart_din(b_din), .receive_start(b_rs),
        .receive_busy(b_rb), .receive_finish(b_rf), .receive_data(b_rd),
        .receive_parity_err(b_pe), .receive_frame_err(b_fe));

    uart_trx #(.BAUD(B), .DATA_BITS(8), .PARITY(1), .STOP_BITS(1)) dut_c (
        .clk(clk), .rst(rst), .send_start(c_ss), .send_data(c_sd), .send_busy(c_busy),
        .send_finish(c_fin), .uart_dout(c_dout), .uart_din(c_din), .receive_start(c_rs),
        .receive_busy(c_rb), .receive_finish(c_rf), .receive_data(c_rd),
        .receive_parity_err(c_pe), .receive_frame_err(c_fe));

    // Frame model: bit i of the result is the line level during serial bit i.
    function automatic logic [15:0] frame_bits(input logic [7:0] d, input int dbits,
                                               input int par, input int stops);
        logic [15:0] f;
        int ones;
        f    = '1;
        f[0] = 1'b0;
        ones = 0;
        for (int i = 0; i < dbits; i++) begin
            f[1+i] = d[i];
            if (d[i]) ones++;
        end
        if (par == 1) f[1+dbits] = (ones % 2 == 0);
        if (par == 2) f[1+dbits] = (ones % 2 == 1);
        return f;
    endfunction

    function automatic int frame_len(input int dbits, input int par, input int stops);
        return 1 + dbits + ((par != 0) ? 1 : 0) + stops;
    endfunction

    task automatic test_reset();
        rst = 1'b1;
        repeat (3) @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
        tests++;
        if ({a_dout, a_busy, a_fin, a_rs, a_rb, a_rf, a_pe, a_fe, a_rd} !== 16'h8000) begin
            errors++;
            $display("FAIL reset_a got %h expected 8000", {a_dout, a_busy, a_fin, a_rs, a_rb, a_rf, a_pe, a_fe, a_rd});
        end
        tests++;
        if ({b_dout, b_busy, b_fin, b_rs, b_rb, b_rf, b_pe, b_fe, b_rd} !== 15'h4000) begin
            errors++;
            $display("FAIL reset_b got %h expected 4000", {b_dout, b_busy, b_fin, b_rs, b_rb, b_rf, b_pe, b_fe, b_rd});
        end
        tests++;
        if ({c_dout, c_busy, c_fin, c_rs, c_rb, c_rf, c_pe, c_fe, c_rd} !== 16'h8000) begin
            errors++;
            $display("FAIL reset_c got %h expected 8000", {c_dout, c_busy, c_fin, c_rs, c_rb, c_rf, c_pe, c_fe, c_rd});
        end
    endtask

    task automatic test_tx_8n1(input logic [7:0] d);
        logic [15:0] fr, obs, m;
        logic [2:0]  bz;
        int nb, nfin, fin_c;
        fr    = frame_bits(d, 8, 0, 1);
        nb    = frame_len(8, 0, 1);
        m     = 16'((1 << nb) - 1);
        obs   = '0;
        bz    = '0;
        nfin  = 0;
        fin_c = -1;
        a_loop = 1'b0;
        for (int c = 0; c <= nb * B + 2; c++) begin
            @(negedge clk);
            if (c > 0 && c <= nb * B && ((c - 1) % B) == B / 2) obs[(c - 1) / B] = a_dout;
            if (a_fin) begin nfin++; fin_c = c; end
            if (c == 1)          bz[2] = a_busy;
            if (c == nb * B)     bz[1] = a_busy;
            if (c == nb * B + 1) bz[0] = a_busy;
            a_ss = (c == 0);
            if (c == 0) a_sd = d;
        end
        tests++;
        if ((obs & m) !== (fr & m)) begin
            errors++;
            $display("FAIL tx8n1_frame data %h got %h expected %h", d, obs & m, fr & m);
        end
        tests++;
        if (nfin != 1 || fin_c != nb * B) begin
            errors++;
            $display("FAIL tx8n1_finish count %0d at %0d expected 1 at %0d", nfin, fin_c, nb * B);
        end
        tests++;
        if (bz !== 3'b110) begin
            errors++;
            $display("FAIL tx8n1_busy got %b expected 110", bz);
        end
    endtask

    task automatic test_loop_7e2(input logic [6:0] d);
        logic [15:0] fr, obs, m;
        logic [6:0]  rd;
        logic        pe, fe;
        int nb, ntf, tf, nrs, rs_c, nrf, rf_c, exp_rf;
        fr  = frame_bits({1'b0, d}, 7, 2, 2);
        nb  = frame_len(7, 2, 2);
        m   = 16'((1 << nb) - 1);
        obs = '0;
        ntf = 0; tf = -1; nrs = 0; rs_c = -1; nrf = 0; rf_c = -1;
        rd  = '0; pe = 1'bx; fe = 1'bx;
        for (int c = 0; c <= nb * B + 20; c++) begin
            @(negedge clk);
            if (c > 0 && c <= nb * B && ((c - 1) % B) == B / 2) obs[(c - 1) / B] = b_dout;
            if (b_fin) begin ntf++; tf = c; end
            if (b_rs) begin nrs++; rs_c = c; end
            if (b_rf) begin nrf++; rf_c = c; rd = b_rd; pe = b_pe; fe = b_fe; end
            b_ss = (c == 0);
            if (c == 0) b_sd = d;
        end
        // line goes low at cycle 1, the FSM sees it 3 cycles later
        exp_rf = 1 + 3 + B / 2 + (nb - 1) * B;
        tests++;
        if ((obs & m) !== (fr & m)) begin
            errors++;
            $display("FAIL loop7e2_txframe data %h got %h expected %h", d, obs & m, fr & m);
        end
        tests++;
        if (ntf != 1 || tf != nb * B) begin
            errors++;
            $display("FAIL loop7e2_txfinish count %0d at %0d expected 1 at %0d", ntf, tf, nb * B);
        end
        tests++;
        if (nrs != 1 || rs_c != 1 + 3 + B / 2) begin
            errors++;
            $display("FAIL loop7e2_rxstart count %0d at %0d expected 1 at %0d", nrs, rs_c, 1 + 3 + B / 2);
        end
        tests++;
        if (nrf != 1 || rf_c != exp_rf) begin
            errors++;
            $display("FAIL loop7e2_rxfinish count %0d at %0d expected 1 at %0d", nrf, rf_c, exp_rf);
        end
        tests++;
        if ({rd, pe, fe} !== {d, 2'b00}) begin
            errors++;
            $display("FAIL loop7e2_rxdata got %h pe %b fe %b expected %h pe 0 fe 0", rd, pe, fe, d);
        end
    endtask

    // Drives bit i of fr for bl cycles each onto the 8O1 receiver, then idles high.
    task automatic rx_run_c(input logic [15:0] fr, input int nbits, input int bl, input int idle,
                            output int nrs, output int nrf, output int rf_c,
                            output logic [7:0] rd, output logic pe, output logic fe,
                            output logic rb_seen, output logic rb_end);
        nrs = 0; nrf = 0; rf_c = -1; rd = '0; pe = 1'bx; fe = 1'bx; rb_seen = 1'b0;
        for (int c = 0; c < nbits * bl + idle; c++) begin
            @(negedge clk);
            if (c_rs) nrs++;
            if (c_rf) begin nrf++; rf_c = c; rd = c_rd; pe = c_pe; fe = c_fe; end
            if (c_rb) rb_seen = 1'b1;
            c_din = (c < nbits * bl) ? fr[c / bl] : 1'b1;
        end
        rb_end = c_rb;
    endtask

    task automatic test_rx_errors();
        logic [15:0] fr;
        logic [7:0]  d, rd;
        logic        pe, fe, rbs, rbe, exp_pe, exp_fe;
        int nrs, nrf, rf_c, nbits, exp_rf;
        for (int t = 0; t < 6; t++) begin
            d  = 8'($urandom);
            fr = frame_bits(d, 8, 1, 1);
            exp_pe = (t == 1);
            exp_fe = (t == 2 || t == 3);
            nbits  = (t == 3) ? 14 : 11;
            if (t == 1) fr[9] = ~fr[9];
            if (t == 2) fr[10] = 1'b0;
            if (t == 3) fr[13:10] = 4'b0000;
            rx_run_c(fr, nbits, B, 2 * B, nrs, nrf, rf_c, rd, pe, fe, rbs, rbe);
            exp_rf = 3 + B / 2 + 10 * B;
            tests++;
            if (nrs != 1 || nrf != 1 || rf_c != exp_rf) begin
                errors++;
                $display("FAIL rx8o1_timing case %0d starts %0d finishes %0d at %0d expected 1 1 at %0d",
                         t, nrs, nrf, rf_c, exp_rf);
            end
            tests++;
            if ({rd, pe, fe, rbe} !== {d, exp_pe, exp_fe, 1'b0}) begin
                errors++;
                $display("FAIL rx8o1_result case %0d got %h pe %b fe %b busy %b expected %h pe %b fe %b busy 0",
                         t, rd, pe, fe, rbe, d, exp_pe, exp_fe);
            end
        end
    endtask

    task automatic test_false_start();
        logic [7:0] rd;
        logic       pe, fe, rbs, rbe;
        int nrs, nrf, rf_c;
        rx_run_c(16'hFFFE, 1, 5, 3 * B, nrs, nrf, rf_c, rd, pe, fe, rbs, rbe);
        tests++;
        if (nrs != 0 || nrf != 0) begin
            errors++;
            $display("FAIL false_start_pulses starts %0d finishes %0d expected 0 0", nrs, nrf);
        end
        tests++;
        if ({rbs, rbe} !== 2'b10) begin
            errors++;
            $display("FAIL false_start_busy seen %b end %b expected seen 1 end 0", rbs, rbe);
        end
    endtask

    task automatic test_back_to_back(input logic [7:0] d0, input logic [7:0] d1);
        int         tf[$];
        logic [7:0] rq[$];
        int nb, t1;
        nb = frame_len(8, 0, 1);
        t1 = nb * B + 1;
        a_loop = 1'b1;
        for (int c = 0; c <= 2 * nb * B + 40; c++) begin
            @(negedge clk);
            if (a_fin) tf.push_back(c);
            if (a_rf) rq.push_back(a_rd);
            a_ss = (c == 0 || c == 50 || c == nb * B || c == t1);
            a_sd = (c == 0) ? d0 : (c == t1) ? d1 : (d1 ^ 8'h5A);
        end
        a_ss   = 1'b0;
        a_loop = 1'b0;
        tests++;
        if (tf.size() != 2 || tf[0] != nb * B || tf[1] != t1 + nb * B) begin
            errors++;
            $display("FAIL b2b_txfinish count %0d expected 2 at %0d and %0d", tf.size(), nb * B, t1 + nb * B);
        end
        tests++;
        if (rq.size() != 2 || rq[0] !== d0 || rq[1] !== d1) begin
            errors++;
            $display("FAIL b2b_rxdata count %0d first %h second %h expected 2 %h %h",
                     rq.size(), (rq.size() > 0) ? rq[0] : 8'hxx, (rq.size() > 1) ? rq[1] : 8'hxx, d0, d1);
        end
    endtask

    task automatic test_reset_mid();
        logic [15:0] fr;
        logic [7:0]  d;
        d  = 8'($urandom);
        fr = frame_bits(d, 8, 0, 1);
        a_loop = 1'b0;
        for (int c = 0; c <= 5 * B; c++) begin
            @(negedge clk);
            a_ss  = (c == 0);
            a_sd  = d;
            a_drv = fr[c / B];
        end
        a_ss  = 1'b0;
        rst   = 1'b1;
        a_drv = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        tests++;
        if ({a_dout, a_busy, a_rb, a_rf, a_rd} !== 12'h800) begin
            errors++;
            $display("FAIL reset_mid got dout %b sbusy %b rbusy %b rfin %b rdata %h expected 1 0 0 0 00",
                     a_dout, a_busy, a_rb, a_rf, a_rd);
        end
        repeat (4) @(negedge clk);
    endtask

    initial begin
        rst    = 1'b1;
        a_ss   = 1'b0; a_sd = '0; a_loop = 1'b0; a_drv = 1'b1;
        b_ss   = 1'b0; b_sd = '0;
        c_ss   = 1'b0; c_sd = '0; c_din = 1'b1;
        test_reset();
        test_tx_8n1(8'hA5);
        repeat (2) test_tx_8n1(8'($urandom));
        test_loop_7e2(7'h53);
        repeat (2) test_loop_7e2(7'($urandom));
        test_rx_errors();
        test_false_start();
        test_back_to_back(8'h00, 8'hFF);
        test_back_to_back(8'($urandom), 8'($urandom));
        test_reset_mid();
        test_back_to_back(8'($urandom), 8'($urandom));
        $display("[TB] %0d tests run, %0d failed", tests, errors);
        $finish;
    end

endmodule
